// File: rtl/sector_stream.sv
// Byte-stream engine on one port of a dual-port sector RAM.
// READ streams a run of RAM bytes out; WRITE commits a stream of bytes into the RAM.
module sector_stream #(
  parameter int DATA = 8,
  parameter int ADDR = 9
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            dir,
  input  logic [ADDR-1:0] base_addr,
  input  logic [ADDR:0]   length,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [DATA-1:0] rd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  input  logic [DATA-1:0] wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [ADDR-1:0] ram_addr,
  output logic            ram_wr,
  output logic [DATA-1:0] ram_din,
  input  logic [DATA-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [ADDR:0] ONE = (ADDR+1)'(1);

  state_t                 state, state_nx;
  logic                   done_nx;
  logic [ADDR-1:0]        addr_cnt;
  logic [ADDR:0]          remaining;
  logic [1:0][DATA-1:0]   fifo;
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             fifo_cnt;
  logic                   inflight;
  logic [2:0]             occ;
  logic                   pop, push, issue, accept, flush, rd_fin, wr_fin;

  assign busy     = (state != IDLE);
  assign rd_valid = (fifo_cnt != 2'd0);
  assign rd_data  = fifo[rd_ptr];
  assign pop      = rd_valid & rd_ready;
  assign push     = inflight;
  assign flush    = abort & busy;

  // Slots committed after this edge: buffered + landing - leaving; never exceeds 2.
  assign occ      = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
  assign issue    = (state == READ) && (remaining != '0) && (occ < 3'd2);
  assign rd_fin   = (state == READ) && (remaining == '0) && !inflight && (fifo_cnt == 2'(pop));

  assign wr_ready = (state == WRITE);
  assign accept   = wr_valid & wr_ready;
  assign wr_fin   = accept && (remaining == ONE);

  assign ram_addr = addr_cnt;
  assign ram_wr   = accept;
  assign ram_din  = wr_data;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) done_nx = 1'b1;
          else              state_nx = dir ? WRITE : READ;
        end
      end
      READ: begin
        if (abort)       state_nx = IDLE;
        else if (rd_fin) begin state_nx = IDLE; done_nx = 1'b1; end
      end
      WRITE: begin
        if (abort)       state_nx = IDLE;
        else if (wr_fin) begin state_nx = IDLE; done_nx = 1'b1; end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      addr_cnt  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nx;
      done     <= done_nx;
      inflight <= issue & ~abort;
      if (state == IDLE && start) begin
        addr_cnt  <= base_addr;
        remaining <= length;
      end else if (issue || accept) begin
        addr_cnt  <= addr_cnt + 1'b1;
        remaining <= remaining - ONE;
      end
    end
  end

  // Read data lands one cycle after issue; abort drops anything buffered or in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else if (flush) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= ram_dout;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_sector_stream.sv
// Directed bench for sector_stream: RAM model, byte/write scoreboards from a shadow
// image of sector contents, and latency/pulse checks against hand-derived numbers.
module tb_sector_stream;

  localparam int DATA = 8;
  localparam int ADDR = 9;
  localparam int SECT = 1 << ADDR;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, dir, abort;
  logic [ADDR-1:0] base_addr;
  logic [ADDR:0]   length;
  logic            busy, done;
  logic [DATA-1:0] rd_data;
  logic            rd_valid, rd_ready;
  logic [DATA-1:0] wr_data;
  logic            wr_valid, wr_ready;
  logic [ADDR-1:0] ram_addr;
  logic            ram_wr;
  logic [DATA-1:0] ram_din, ram_dout;

  sector_stream #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dir(dir), .base_addr(base_addr),
    .length(length), .abort(abort), .busy(busy), .done(done), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [DATA-1:0] mem    [SECT];
  logic [DATA-1:0] shadow [SECT];

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [DATA-1:0] exp_q[$];
  logic [DATA-1:0] got[$];
  logic [ADDR-1:0] wexp_a[$];
  logic [DATA-1:0] wexp_d[$];
  int done_cnt = 0;
  int pop_cnt  = 0;
  int wr_cnt   = 0;

  logic            prev_done  = 1'b0;
  logic            prev_stall = 1'b0;
  logic            prev_abort = 1'b0;
  logic [DATA-1:0] prev_data  = '0;

  // Per-cycle compare against the scoreboards.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy && done) chk("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        done_cnt++;
        chk("done_width", 32'(prev_done), 32'd0);
      end
      if (prev_stall && !prev_abort) begin
        chk("stall_valid", 32'(rd_valid), 32'd1);
        chk("stall_data", 32'(rd_data), 32'(prev_data));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        got.push_back(rd_data);
        pop_cnt++;
      end
      if (ram_wr) begin
        if (wexp_a.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          chk("wr_addr", 32'(ram_addr), 32'(wexp_a.pop_front()));
          chk("wr_data", 32'(ram_din), 32'(wexp_d.pop_front()));
        end
        wr_cnt++;
      end
      prev_done  = done;
      prev_stall = rd_valid && !rd_ready;
      prev_abort = abort;
      prev_data  = rd_data;
    end else begin
      prev_done  = 1'b0;
      prev_stall = 1'b0;
    end
  end

  // rd_ready driver: held high, or shifted out of a pattern (LSB first, refills with 1).
  logic        bp_en  = 1'b0;
  logic [31:0] bp_pat = '1;
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (bp_en) begin
        rd_ready = bp_pat[0];
        bp_pat   = {1'b1, bp_pat[31:1]};
      end else rd_ready = 1'b1;
    end
  end

  // Called at posedge+1; returns at E0+1 where E0 is the edge that samples start.
  task automatic do_start(input logic d, input int b, input int len);
    start = 1'b1; dir = d; base_addr = ADDR'(b); length = (ADDR+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic start_read(input int b, input int len);
    got.delete();
    pop_cnt = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(shadow[(b + i) % SECT]);
    do_start(1'b0, b, len);
  endtask

  // k = number of edges after the reference edge before done is seen high.
  task automatic wait_done(input int budget, output int k, output int fv);
    k = 0; fv = -1;
    forever begin
      @(negedge clk);
      if (rd_valid && fv < 0) fv = k;
      if (done) break;
      k++;
      if (k > budget) begin
        chk("done_timeout", 32'(k), 32'(budget));
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  int k, fv, d0, w0, n;
  int gaps[4] = '{0, 2, 1, 3};

  initial begin
    for (int i = 0; i < SECT; i++) begin
      mem[i]    = DATA'(i);
      shadow[i] = DATA'(i);
    end
    reset_n = 1'b0; start = 1'b0; dir = 1'b0; base_addr = '0; length = '0;
    abort = 1'b0; wr_data = '0; wr_valid = 1'b0;

    // Reset values
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Full-sector read burst
    start_read(0, 512);
    chk("burst_first_addr", 32'(ram_addr), 32'd0);
    wait_done(600, k, fv);
    chk("burst_first_valid", 32'(fv), 32'd2);
    chk("burst_done_lat", 32'(k), 32'd514);
    chk("burst_count", 32'(got.size()), 32'd512);
    chk("burst_b0", 32'(got[0]), 32'h00);
    chk("burst_b255", 32'(got[255]), 32'hFF);
    chk("burst_b256", 32'(got[256]), 32'h00);
    chk("burst_b511", 32'(got[511]), 32'hFF);
    chk("burst_done_cnt", 32'(done_cnt), 32'd1);
    chk("burst_q_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure: 1,0,0,1, five-cycle stall, then 1,0,1...
    bp_en = 1'b1; bp_pat = 32'hFFFF_D04F;
    start_read(16, 8);
    wait_done(100, k, fv);
    bp_en = 1'b0;
    chk("bp_first_valid", 32'(fv), 32'd2);
    chk("bp_count", 32'(got.size()), 32'd8);
    chk("bp_b0", 32'(got[0]), 32'h10);
    chk("bp_b7", 32'(got[7]), 32'h17);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Wrapping write with gapped wr_valid
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      wexp_a.push_back(ADDR'((510 + i) % SECT));
      wexp_d.push_back(DATA'(8'hA0 + i));
      shadow[(510 + i) % SECT] = DATA'(8'hA0 + i);
    end
    do_start(1'b1, 510, 4);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        wr_valid = 1'b0;
        @(posedge clk); #1;
      end
      wr_valid = 1'b1; wr_data = DATA'(8'hA0 + i);
      n = 0;
      @(negedge clk);
      if (i == 0) chk("wr_first_ready", 32'(wr_ready), 32'd1);
      while (!wr_ready && n < 10) begin @(negedge clk); n++; end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_busy_off", 32'(busy), 32'd0);
    chk("wr_hits", 32'(wr_cnt - w0), 32'd4);
    chk("wr_q_empty", 32'(wexp_a.size()), 32'd0);
    @(posedge clk); #1;

    // Read-back across the wrap
    start_read(510, 4);
    wait_done(50, k, fv);
    chk("rb_done_lat", 32'(k), 32'd6);
    chk("rb_b0", 32'(got[0]), 32'hA0);
    chk("rb_b1", 32'(got[1]), 32'hA1);
    chk("rb_b2", 32'(got[2]), 32'hA2);
    chk("rb_b3", 32'(got[3]), 32'hA3);

    // Abort mid-read
    d0 = done_cnt;
    start_read(0, 100);
    n = 0;
    while (pop_cnt < 10 && n < 200) begin @(posedge clk); #2; n++; end
    chk("abort_reached_pops", 32'(pop_cnt >= 10), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    exp_q.delete();
    repeat (5) @(posedge clk); #1;
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    start_read(200, 5);
    wait_done(50, k, fv);
    chk("post_abort_first_valid", 32'(fv), 32'd2);
    chk("post_abort_done_lat", 32'(k), 32'd7);
    chk("post_abort_b0", 32'(got[0]), 32'hC8);
    chk("post_abort_q_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length transfers
    w0 = wr_cnt; n = pop_cnt;
    do_start(1'b0, 5, 0);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("len0_done_off", 32'(done), 32'd0);
    @(posedge clk); #1;
    do_start(1'b1, 7, 0);
    wr_valid = 1'b1;
    @(negedge clk);
    chk("len0w_done", 32'(done), 32'd1);
    @(posedge clk); #1 wr_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("len0_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("len0_no_rd", 32'(pop_cnt - n), 32'd0);

    // Start while busy is ignored
    w0 = wr_cnt;
    start_read(32, 6);
    repeat (2) @(posedge clk); #1;
    do_start(1'b1, 0, 3);
    wait_done(50, k, fv);
    chk("busy_start_done_lat", 32'(k), 32'd5);
    chk("busy_start_count", 32'(got.size()), 32'd6);
    chk("busy_start_b5", 32'(got[5]), 32'h25);
    repeat (2) @(posedge clk); #1;
    chk("busy_start_idle", 32'(busy), 32'd0);
    chk("busy_start_no_wr", 32'(wr_cnt - w0), 32'd0);

    // Asynchronous reset mid-read
    start_read(0, 50);
    repeat (20) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_ram_addr", 32'(ram_addr), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk); #1 reset_n = 1'b1;
    repeat (60) @(posedge clk); #1;
    chk("arst_no_done", 32'(done_cnt), 32'(d0));
    chk("arst_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
